alu_opregs: RTL
===============

// Module: alu_opregs
// PURPOSE
//  Operand/flag register stage feeding the 8-bit adder ALU: register A (accumulator) and register B
//  load from the shared 8-bit bus and drive the ALU operand inputs; the ALU's cf/zf outputs are latched
//  into a flags register. Tracks operand freshness with a 4-state FSM and raises op_ready to the controller.
// PARAMETERS
//  WIDTH     8      datapath width (A, B, bus)
//  A_RST     8'h00  value loaded into A on clr
//  B_RST     8'h00  value loaded into B on clr
// PORTS
//  clk       in   1      system clock, all state updates on rising edge
//  clr       in   1      reset, synchronous, active-high
//  bus_in    in   WIDTH  shared bus read value
//  bus_out   out  WIDTH  registered bus drive; WIDTH'hzz when not driving
//  ai / ao   in   1      load A from bus / drive A onto bus
//  bi / bo   in   1      load B from bus / drive B onto bus
//  fi        in   1      latch cf_in/zf_in into flags
//  cf_in     in   1      ALU carry flag
//  zf_in     in   1      ALU zero flag
//  a_q       out  WIDTH  A contents to ALU operand a
//  b_q       out  WIDTH  B contents to ALU operand b
//  cf_q      out  1      latched carry flag
//  zf_q      out  1      latched zero flag
//  op_ready  out  1      both operands loaded since last flag capture
//  bus_err   out  1      sticky: ao and bo asserted in the same cycle
// BEHAVIOUR
//  - clr (overrides all): A=A_RST, B=B_RST, cf_q=0, zf_q=0, bus_out=zz, bus_err=0, FSM=EMPTY, op_ready=0.
//    Mid-operation clr discards a pending load/capture in that cycle.
//  - Loads: ai -> A<=bus_in, bi -> B<=bus_in, 1-cycle latency; a_q/b_q show new value after the edge.
//  - Bus drive registered: at edge bus_out <= ao ? A(pre-edge) : bo ? B(pre-edge) : zz.
//    ao with ai in the same cycle drives OLD A. ao&bo: A wins, bus_err set, held until clr.
//  - fi: cf_q<=cf_in, zf_q<=zf_in at edge; otherwise flags hold.
//  - FSM (op_ready = state==READY), evaluated per edge, priority fi > loads:
//      EMPTY : ai&bi->READY, ai->A_ONLY, bi->B_ONLY
//      A_ONLY: bi->READY;  B_ONLY: ai->READY
//      READY : fi->EMPTY; fi with ai (result written back to A) -> A_ONLY; fi with ai&bi -> READY
//      fi in any non-READY state -> flags still latched; state -> EMPTY (or per same-cycle loads as above)
//    Unused encodings recover to EMPTY.
//  - No arithmetic here; widths are all WIDTH, no wrap/extension.
// CONFIGURATION
//  ALU_OPREG_SHIFT_EN defined: extra inputs shl, shr (1 bit each). Priority clr > ai > shl > shr.
//    shl: A<={A[W-2:0],0}, cf_q<=A[W-1], zf_q<=(result==0). shr: A<={0,A[W-1:1]}, cf_q<=A[0], zf_q likewise.
//    Shift overrides fi for flags in that cycle; FSM treats shift as an A load (A_ONLY/READY rules).
//  Not defined: shl/shr ports absent; A changes only via ai/clr; flags only via fi/clr.
// STRUCTURE
//  - alu_defs.vh (shared include): WIDTH default, FSM state encodings (EMPTY/A_ONLY/B_ONLY/READY, 2 bits),
//    bus high-Z constant.
//  - Sub-module reg8b: WIDTH-bit register with sync clr, reset value, load enable; instantiated for A and B.
//  - FSM, flag register and bus-drive mux live in alu_opregs.
// TESTING
//  1. clr held 1 cycle after random loads -> a_q=00, b_q=00, cf_q=zf_q=0, op_ready=0, bus_out=zz.
//  2. bus_in=8'h3C,ai; then bus_in=8'hC4,bi -> after 2nd edge a_q=3C, b_q=C4, op_ready=1.
//  3. READY, cf_in=1, zf_in=1, fi -> cf_q=1, zf_q=1, op_ready=0 next cycle (state EMPTY).
//  4. A=55, bus_in=AA, ai&ao same cycle -> bus_out=55 that edge, a_q=AA after; next ao -> bus_out=AA.
//  5. ao&bo together (A=11,B=22) -> bus_out=11, bus_err=1 and stays 1 until clr.
//  6. SHIFT_EN: A=8'h81, shl -> a_q=02, cf_q=1, zf_q=0; A=8'h01, shr -> a_q=00, cf_q=1, zf_q=1.

Source files
------------

// File: rtl/alu_opregs_pkg.sv
// Shared definitions for the ALU operand/flag register stage.
// Provides the default datapath width, FSM state encoding and the load-step helper.
package alu_opregs_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        A_ONLY = 2'b01,
        B_ONLY = 2'b10,
        READY  = 2'b11
    } op_state_t;

    // Advance operand freshness given this cycle's A/B loads.
    function automatic op_state_t load_step(
        input op_state_t s,
        input logic      a_ld,
        input logic      b_ld
    );
        op_state_t n;
        n = EMPTY;
        case (s)
            EMPTY: begin
                if (a_ld && b_ld) n = READY;
                else if (a_ld)    n = A_ONLY;
                else if (b_ld)    n = B_ONLY;
                else              n = EMPTY;
            end
            A_ONLY:  n = b_ld ? READY : A_ONLY;
            B_ONLY:  n = a_ld ? READY : B_ONLY;
            READY:   n = READY;
            default: n = EMPTY;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/alu_opregs_if.sv
// Bus/control bundle between the controller (master) and the operand stage (slave).
// Signals: bus_in, ai/ao/bi/bo/fi, cf_in/zf_in, [shl/shr if ALU_OPREG_SHIFT_EN], bus_oe, bus_err.
interface alu_opregs_if #(
    parameter int WIDTH = 8
);

    logic [WIDTH-1:0] bus_in;
    logic             ai;
    logic             ao;
    logic             bi;
    logic             bo;
    logic             fi;
    logic             cf_in;
    logic             zf_in;
`ifdef ALU_OPREG_SHIFT_EN
    logic             shl;
    logic             shr;
`endif
    logic             bus_oe;
    logic             bus_err;

`ifdef ALU_OPREG_SHIFT_EN
    modport master (
        output bus_in, ai, ao, bi, bo, fi, cf_in, zf_in, shl, shr,
        input  bus_oe, bus_err
    );
    modport slave (
        input  bus_in, ai, ao, bi, bo, fi, cf_in, zf_in, shl, shr,
        output bus_oe, bus_err
    );
`else
    modport master (
        output bus_in, ai, ao, bi, bo, fi, cf_in, zf_in,
        input  bus_oe, bus_err
    );
    modport slave (
        input  bus_in, ai, ao, bi, bo, fi, cf_in, zf_in,
        output bus_oe, bus_err
    );
`endif

endinterface

// File: rtl/alu_opregs_reg8b.sv
// WIDTH-bit register with synchronous clear to RST_VAL and load enable.
// Ports: clk, clr, en, d -> q.
module alu_opregs_reg8b #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr)     q <= RST_VAL;
        else if (en) q <= d;
    end

endmodule

// File: rtl/alu_opregs.sv
// Operand A/B registers, flag register, registered bus drive and operand-freshness FSM.
// Ports: clk, clr (sync, active-high), io (alu_opregs_if.slave), bus_out, a_q, b_q, cf_q, zf_q,
// op_ready. Optional macro ALU_OPREG_SHIFT_EN adds shl/shr shifting of A with flag update.
module alu_opregs
    import alu_opregs_pkg::*;
#(
    parameter int               WIDTH = WIDTH_DEF,
    parameter logic [WIDTH-1:0] A_RST = '0,
    parameter logic [WIDTH-1:0] B_RST = '0
) (
    input  logic             clk,
    input  logic             clr,
    alu_opregs_if.slave      io,
    output logic [WIDTH-1:0] bus_out,
    output logic [WIDTH-1:0] a_q,
    output logic [WIDTH-1:0] b_q,
    output logic             cf_q,
    output logic             zf_q,
    output logic             op_ready
);

    logic             a_ld;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] drv_q;
    logic             oe_q;
    logic             err_q;
    op_state_t        state_q;
    op_state_t        state_d;

`ifdef ALU_OPREG_SHIFT_EN
    logic             shift_act;
    logic [WIDTH-1:0] sh_res;
    logic             sh_cf;

    // ai beats any shift; shl beats shr
    always_comb begin
        shift_act = ~io.ai & (io.shl | io.shr);
        sh_res    = io.shl ? {a_q[WIDTH-2:0], 1'b0}
                           : {1'b0, a_q[WIDTH-1:1]};
        sh_cf     = io.shl ? a_q[WIDTH-1] : a_q[0];
        a_ld      = io.ai | shift_act;
        a_d       = io.ai ? io.bus_in : sh_res;
    end
`else
    always_comb begin
        a_ld = io.ai;
        a_d  = io.bus_in;
    end
`endif

    alu_opregs_reg8b #(
        .WIDTH   (WIDTH),
        .RST_VAL (A_RST)
    ) u_a (
        .clk (clk),
        .clr (clr),
        .en  (a_ld),
        .d   (a_d),
        .q   (a_q)
    );

    alu_opregs_reg8b #(
        .WIDTH   (WIDTH),
        .RST_VAL (B_RST)
    ) u_b (
        .clk (clk),
        .clr (clr),
        .en  (io.bi),
        .d   (io.bus_in),
        .q   (b_q)
    );

    // A shift result takes the flags over a same-cycle fi.
    always_ff @(posedge clk) begin
        if (clr) begin
            cf_q <= 1'b0;
            zf_q <= 1'b0;
`ifdef ALU_OPREG_SHIFT_EN
        end else if (shift_act) begin
            cf_q <= sh_cf;
            zf_q <= (sh_res == '0);
`endif
        end else if (io.fi) begin
            cf_q <= io.cf_in;
            zf_q <= io.zf_in;
        end
    end

    // Drive captures pre-edge register contents; A wins a collision.
    always_ff @(posedge clk) begin
        if (clr) begin
            drv_q <= '0;
            oe_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            if (io.ao) begin
                drv_q <= a_q;
                oe_q  <= 1'b1;
            end else if (io.bo) begin
                drv_q <= b_q;
                oe_q  <= 1'b1;
            end else begin
                oe_q  <= 1'b0;
            end
            if (io.ao && io.bo) err_q <= 1'b1;
        end
    end

    assign bus_out    = oe_q ? drv_q : {WIDTH{1'bz}};
    assign io.bus_oe  = oe_q;
    assign io.bus_err = err_q;

    always_ff @(posedge clk) begin
        if (clr) state_q <= EMPTY;
        else     state_q <= state_d;
    end

    // A flag capture consumes the operands; same-cycle loads refill from EMPTY.
    always_comb begin
        state_d  = EMPTY;
        if (io.fi) state_d = load_step(EMPTY, a_ld, io.bi);
        else       state_d = load_step(state_q, a_ld, io.bi);
        op_ready = (state_q == READY);
    end

endmodule
